// File: rtl/ma_pkg.sv
// Shared datapath constants so sibling operand registers and the parent agree on width.
package ma_pkg;

    localparam int unsigned OPERAND_WIDTH = 4;

endpackage

// File: rtl/ma_if.sv
// Signal bundle for a parent controller driving one operand register.
interface ma_if
    import ma_pkg::*;
#(
    parameter int unsigned WIDTH = OPERAND_WIDTH
);

    logic             ld;
    logic             clr;
    logic [WIDTH-1:0] da;
    logic [WIDTH-1:0] qa;

    modport master (
        output ld,
        output clr,
        output da,
        input  qa
    );

    modport slave (
        input  ld,
        input  clr,
        input  da,
        output qa
    );

endinterface

// File: rtl/ma.sv
// Loadable operand register with synchronous clear; clear takes priority over load.
module ma
    import ma_pkg::*;
#(
    parameter int unsigned WIDTH = OPERAND_WIDTH
) (
    input  logic             ld,
    input  logic             clr,
    input  logic             clk,
    input  logic [WIDTH-1:0] da,
    output logic [WIDTH-1:0] qa
);

    // Initialiser keeps simulation X-free before the first clear.
    logic [WIDTH-1:0] qa_q = '0;
    logic [WIDTH-1:0] qa_d;

    always_comb begin
        qa_d = qa_q;
        if (ld) begin
            qa_d = da;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            qa_q <= '0;
        end else begin
            qa_q <= qa_d;
        end
    end

    assign qa = qa_q;

endmodule

// File: tb/tb_ma.sv
// Self-checking bench for the operand register: directed scenarios plus a random run.
module tb_ma;
    import ma_pkg::*;

    localparam int unsigned W = OPERAND_WIDTH;

    logic clk;
    int   errors;
    int   checks;
    logic [W-1:0] model_q;

    ma_if #(.WIDTH(W)) bus ();

    ma #(.WIDTH(W)) dut (
        .ld  (bus.ld),
        .clr (bus.clr),
        .clk (clk),
        .da  (bus.da),
        .qa  (bus.qa)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive inputs away from the edge, advance one edge, update the reference, settle.
    task automatic cycle(input logic l, input logic c, input logic [W-1:0] d);
        bus.ld  = l;
        bus.clr = c;
        bus.da  = d;
        @(posedge clk);
        if (c)      model_q = '0;
        else if (l) model_q = d;
        #1;
    endtask

    task automatic test_powerup;
        checks++;
        if (bus.qa !== 4'h0) begin
            errors++;
            $display("FAIL powerup: qa=%h expected=%h", bus.qa, 4'h0);
        end
    endtask

    task automatic test_reset;
        cycle(1'b0, 1'b1, 4'h4);
        checks++;
        if (bus.qa !== 4'h0) begin
            errors++;
            $display("FAIL reset: qa=%h expected=%h", bus.qa, 4'h0);
        end
    endtask

    task automatic test_load;
        cycle(1'b1, 1'b0, 4'h4);
        checks++;
        if (bus.qa !== 4'h4) begin
            errors++;
            $display("FAIL load: qa=%h expected=%h", bus.qa, 4'h4);
        end
    endtask

    task automatic test_hold;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b0, 4'hA);
            checks++;
            if (bus.qa !== 4'h4) begin
                errors++;
                $display("FAIL hold[%0d]: qa=%h expected=%h", i, bus.qa, 4'h4);
            end
        end
    endtask

    task automatic test_clear_priority;
        cycle(1'b1, 1'b1, 4'hF);
        checks++;
        if (bus.qa !== 4'h0) begin
            errors++;
            $display("FAIL clear_priority: qa=%h expected=%h", bus.qa, 4'h0);
        end
    endtask

    task automatic test_back_to_back;
        logic [W-1:0] seq [3];
        seq[0] = 4'h1;
        seq[1] = 4'h8;
        seq[2] = 4'hF;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b0, seq[i]);
            checks++;
            if (bus.qa !== seq[i]) begin
                errors++;
                $display("FAIL back_to_back[%0d]: qa=%h expected=%h", i, bus.qa, seq[i]);
            end
        end
    endtask

    task automatic test_clear_midstream;
        cycle(1'b0, 1'b1, 4'hF);
        checks++;
        if (bus.qa !== 4'h0) begin
            errors++;
            $display("FAIL clear_midstream: qa=%h expected=%h", bus.qa, 4'h0);
        end
        cycle(1'b1, 1'b0, 4'h3);
        checks++;
        if (bus.qa !== 4'h3) begin
            errors++;
            $display("FAIL load_after_clear: qa=%h expected=%h", bus.qa, 4'h3);
        end
    endtask

    task automatic test_random;
        logic         l;
        logic         c;
        logic [W-1:0] d;
        for (int i = 0; i < 300; i++) begin
            l = 1'($urandom_range(0, 1));
            c = ($urandom_range(0, 7) == 0);
            d = W'($urandom);
            cycle(l, c, d);
            checks++;
            if (bus.qa !== model_q) begin
                errors++;
                $display("FAIL random[%0d] ld=%b clr=%b da=%h: qa=%h expected=%h",
                         i, l, c, d, bus.qa, model_q);
            end
        end
    endtask

    initial begin
        errors  = 0;
        checks  = 0;
        model_q = '0;
        bus.ld  = 1'b0;
        bus.clr = 1'b0;
        bus.da  = '0;
        #1;
        test_powerup();
        test_reset();
        test_load();
        test_hold();
        test_clear_priority();
        test_load();
        test_back_to_back();
        test_clear_midstream();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
